timestamp_deserializer_param: RTL

//  Parametrised successor of the byte-parallel timestamp receiver. Captures a
//  sec/usec timestamp message sent as consecutive bytes after a pre_stb.

---
 rtl/timestamp_deserializer_param_if.sv | 25 ++
 rtl/timestamp_deserializer_param.sv | 118 +++++++++++
 2 files changed

// File: rtl/timestamp_deserializer_param_if.sv
// Byte-bus and timestamp output bundle for timestamp_deserializer_param.
// The master drives the byte stream; the slave (the deserializer) drives the timestamp outputs.
interface timestamp_deserializer_param_if #(
    parameter int SEC_BITS  = 32,
    parameter int USEC_BITS = 20
);
    logic                 pre_stb;
    logic [7:0]           tdata;
    logic [SEC_BITS-1:0]  sec;
    logic [USEC_BITS-1:0] usec;
    logic                 done;
    logic                 err;
    logic                 valid;
    logic                 busy;

    modport master (
        output pre_stb, tdata,
        input  sec, usec, done, err, valid, busy
    );

    modport slave (
        input  pre_stb, tdata,
        output sec, usec, done, err, valid, busy
    );
endinterface

// File: rtl/timestamp_deserializer_param.sv
// Byte-parallel sec/usec timestamp receiver with atomic output update and restart detection.
// Define TIMESTAMP_CHECKSUM_EN to expect a trailing XOR checksum byte after the usec bytes.
module timestamp_deserializer_param #(
    parameter int SEC_BITS  = 32,
    parameter int USEC_BITS = 20
) (
    input logic                           clk,
    input logic                           rst,
    timestamp_deserializer_param_if.slave bus
);
    localparam int NBYTES     = SEC_BITS / 8 + (USEC_BITS + 7) / 8;
    localparam int TOTAL_BITS = SEC_BITS + USEC_BITS;
`ifdef TIMESTAMP_CHECKSUM_EN
    localparam int L_BYTES    = NBYTES + 1;
`else
    localparam int L_BYTES    = NBYTES;
`endif
    localparam int IDX_W      = $clog2(L_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(L_BYTES - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RECV = 1'b1;

    logic [0:0]           state;
    logic [IDX_W-1:0]     idx;
    logic [TOTAL_BITS-1:0] shadow;
    logic [TOTAL_BITS-1:0] assembled;
    logic [SEC_BITS-1:0]  sec_q;
    logic [USEC_BITS-1:0] usec_q;
    logic                 done_q;
    logic                 err_q;
    logic                 valid_q;
    logic                 accept;

`ifdef TIMESTAMP_CHECKSUM_EN
    logic [7:0] xor_acc;

    assign accept    = (bus.tdata == xor_acc);
    assign assembled = shadow;
`else
    assign accept = 1'b1;

    // The final data byte is folded in directly so the outputs load on its own edge.
    always_comb begin
        assembled = shadow;
        for (int j = 0; j < TOTAL_BITS; j++) begin
            if (j / 8 == NBYTES - 1) begin
                assembled[j] = bus.tdata[j % 8];
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            idx     <= '0;
            shadow  <= '0;
            sec_q   <= '0;
            usec_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
`ifdef TIMESTAMP_CHECKSUM_EN
            xor_acc <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.pre_stb) begin
                        state <= ST_RECV;
                        idx   <= '0;
                    end
                end
                ST_RECV: begin
                    if (idx == LAST_IDX) begin
                        if (accept) begin
                            sec_q   <= assembled[SEC_BITS-1:0];
                            usec_q  <= assembled[TOTAL_BITS-1:SEC_BITS];
                            done_q  <= 1'b1;
                            valid_q <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                        idx <= '0;
                        // A strobe on the last byte chains straight into the next message.
                        if (!bus.pre_stb) begin
                            state <= ST_IDLE;
                        end
                    end else if (bus.pre_stb) begin
                        err_q <= 1'b1;
                        idx   <= '0;
                    end else begin
                        for (int j = 0; j < TOTAL_BITS; j++) begin
                            if (idx == IDX_W'(j / 8)) begin
                                shadow[j] <= bus.tdata[j % 8];
                            end
                        end
`ifdef TIMESTAMP_CHECKSUM_EN
                        xor_acc <= (idx == '0) ? bus.tdata : (xor_acc ^ bus.tdata);
`endif
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.sec   = sec_q;
    assign bus.usec  = usec_q;
    assign bus.done  = done_q;
    assign bus.err   = err_q;
    assign bus.valid = valid_q;
    assign bus.busy  = (state == ST_RECV);
endmodule
